// File: rtl/fft8_input_buffer.sv
// fft8_input_buffer
//   Ping-pong input buffer for the 8-point butterfly stage. Serial complex samples
//   arrive over a valid/ready stream. Each group of eight is gathered into a write
//   bank. A completed bank is swapped into the read role, where it is held as a
//   stable parallel frame until the downstream side consumes it.
//
// Optional build macro:
//   FFT_IN_BITREV_EN - the k-th sample of a frame lands in slot bitrev3(k)
//                      instead of slot k.
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_i          asynchronous reset, active low
//   s_data_i       input sample {re, im}, each component DW bits
//   s_valid_i      input sample valid
//   s_last_i       marks the 8th sample of a frame
//   s_ready_o      buffer can accept a sample (depends on registers only)
//   frame_o        parallel frame; element k is slot k
//   frame_valid_o  frame_o holds a complete frame
//   frame_ready_i  downstream consumes the frame
//   err_o          sticky framing error; cleared only by reset

module fft8_input_buffer #(
  parameter int unsigned DW = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2*DW-1:0]          s_data_i,
  input  logic                     s_valid_i,
  input  logic                     s_last_i,
  output logic                     s_ready_o,
  output logic [7:0][2*DW-1:0]     frame_o,
  output logic                     frame_valid_o,
  input  logic                     frame_ready_i,
  output logic                     err_o
);

  // State bits are {r_valid, w_full}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [2:0]              r_wr_idx;
  logic [2:0]              w_wr_idx_nxt;
  logic [2:0]              w_slot;
  logic                    r_sel;     // 0: bank0 is W, bank1 is R
  logic                    r_err;
  logic [7:0][2*DW-1:0]    r_bank0;
  logic [7:0][2*DW-1:0]    r_bank1;

  logic w_accept;
  logic w_last_slot;
  logic w_complete;
  logic w_abort;
  logic w_consume;
  logic w_swap;

  assign s_ready_o     = ~r_state[0];
  assign frame_valid_o = r_state[1];
  assign err_o         = r_err;
  assign frame_o       = r_sel ? r_bank0 : r_bank1;

  assign w_accept    = s_valid_i & ~r_state[0];
  assign w_last_slot = (r_wr_idx == 3'd7);
  // The 8th sample always completes a frame; a missing s_last_i only flags an error.
  assign w_complete  = w_accept & w_last_slot;
  assign w_abort     = w_accept & s_last_i & ~w_last_slot;
  assign w_consume   = r_state[1] & frame_ready_i;

`ifdef FFT_IN_BITREV_EN
  assign w_slot = {r_wr_idx[0], r_wr_idx[1], r_wr_idx[2]};
`else
  assign w_slot = r_wr_idx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_complete) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_complete && w_consume) begin
          w_swap = 1'b1;
        end else if (w_complete) begin
          w_state_nxt = ST_TWO;
        end else if (w_consume) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_consume) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_wr_idx_nxt = r_wr_idx;
    if (w_abort) begin
      w_wr_idx_nxt = 3'd0;
    end else if (w_accept) begin
      w_wr_idx_nxt = r_wr_idx + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_EMPTY;
      r_wr_idx <= 3'd0;
      r_sel    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      if (w_swap) begin
        r_sel <= ~r_sel;
      end
      if (w_accept && (s_last_i != w_last_slot)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Banks are cleared on reset so no stale frame is ever visible afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else if (w_accept) begin
      if (!r_sel) begin
        r_bank0[w_slot] <= s_data_i;
      end else begin
        r_bank1[w_slot] <= s_data_i;
      end
    end
  end

endmodule

// File: tb/tb_fft8_input_buffer.sv
module tb_fft8_input_buffer;

  localparam int unsigned DW = 25;
  localparam int unsigned SW = 2 * DW;

  typedef logic [7:0][SW-1:0] frame_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [SW-1:0]     s_data_i = '0;
  logic              s_valid_i = 1'b0;
  logic              s_last_i = 1'b0;
  logic              s_ready_o;
  frame_t            frame_o;
  logic              frame_valid_o;
  logic              frame_ready_i = 1'b0;
  logic              err_o;

  fft8_input_buffer #(.DW(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_last_i      (s_last_i),
    .s_ready_o     (s_ready_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [8*SW-1:0] obs,
                       input logic [8*SW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: complete frames waiting for the consumer, plus the partial frame.
  frame_t        m_q[$];
  logic [SW-1:0] m_part[$];
  logic          m_err;
  logic          m_fresh;   // no frame presented since reset: frame_o must be zero
  logic          m_acc;     // last edge accepted a sample

  function automatic logic [2:0] slot_of(input int k);
    logic [2:0] kk;
    kk = 3'(k);
`ifdef FFT_IN_BITREV_EN
    return {kk[0], kk[1], kk[2]};
`else
    return kk;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_err   = 1'b0;
    m_fresh = 1'b1;
    m_acc   = 1'b0;
  endtask

  // Called right after a rising edge with the inputs that were present at that edge.
  task automatic model_step();
    logic   acc;
    frame_t f;
    if (!rst_i) begin
      model_reset();
      return;
    end
    acc = s_valid_i && (m_q.size() < 2);
    if (m_q.size() > 0 && frame_ready_i) void'(m_q.pop_front());
    m_acc = acc;
    if (acc) begin
      m_part.push_back(s_data_i);
      if (m_part.size() == 8) begin
        f = '0;
        for (int k = 0; k < 8; k++) f[slot_of(k)] = m_part[k];
        m_q.push_back(f);
        m_part.delete();
        if (!s_last_i) m_err = 1'b1;
      end else if (s_last_i) begin
        m_err = 1'b1;
        m_part.delete();
      end
    end
  endtask

  task automatic compare();
    check("frame_valid", 400'(frame_valid_o), 400'(m_q.size() > 0));
    check("s_ready", 400'(s_ready_o), 400'(m_q.size() < 2));
    check("err", 400'(err_o), 400'(m_err));
    if (m_q.size() > 0) begin
      check("frame_data", frame_o, m_q[0]);
      m_fresh = 1'b0;
    end else if (m_fresh) begin
      check("frame_zero", frame_o, '0);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic cycle(input logic v, input logic [SW-1:0] d, input logic l,
                       input logic rdy);
    s_valid_i     = v;
    s_data_i      = d;
    s_last_i      = l;
    frame_ready_i = rdy;
    @(posedge clk_i);
    #1;
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic send(input logic [SW-1:0] d, input logic l, input logic rdy);
    for (int t = 0; t < 32; t++) begin
      cycle(1'b1, d, l, rdy);
      if (m_acc) return;
    end
    check("send_timeout", 400'(1), 400'(0));
  endtask

  function automatic logic [SW-1:0] nat(input int k);
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    re = DW'(k);
    im = DW'(-k);
    return {re, im};
  endfunction

  function automatic logic [SW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[SW-1:0];
  endfunction

  initial begin
    model_reset();
    @(negedge clk_i);
    compare();
    @(negedge clk_i);
    compare();
    rst_i = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Natural-order frame, consumer always ready.
    for (int k = 0; k < 8; k++) send(nat(k), k == 7, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Stall: two frames with the consumer idle, then a single consume pulse.
    for (int k = 0; k < 16; k++) send(rnd(), (k % 8) == 7, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Continuous stream: 40 samples back to back.
    for (int k = 0; k < 40; k++) send(rnd(), (k % 8) == 7, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Early s_last on index 3, then a clean frame.
    for (int k = 0; k < 4; k++) send(rnd(), k == 3, 1'b1);
    for (int k = 0; k < 8; k++) send(nat(k + 8), k == 7, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset after 5 samples of a frame; a frame also waits in R.
    for (int k = 0; k < 13; k++) send(rnd(), (k % 8) == 7, 1'b0);
    rst_i = 1'b0;
    #1;
    model_reset();
    cycle(1'b1, rnd(), 1'b0, 1'b1);
    cycle(1'b1, rnd(), 1'b0, 1'b1);
    rst_i = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send(nat(k), k == 7, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Random traffic with occasional framing errors.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic l;
      v = ($urandom_range(0, 3) != 0);
      l = (m_part.size() == 7);
      if ($urandom_range(0, 40) == 0) l = ~l;
      cycle(v, rnd(), l, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
